// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding-select generation, load-use stall, branch flush and
// data-memory wait hold for the 5-stage pipeline. Keeps a shadow copy of the
// EX and MEM stage destination/control information.
module hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        id_memwrite_i,
  input  logic        branch_taken_i,
  input  logic        dmem_ready_i,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        id_ex_bubble_o,
  output logic        if_id_flush_o,
  output logic        hold_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;
  localparam logic [7:0] WAIT_LIMIT  = 8'(WAIT_TIMEOUT);
  localparam logic [1:0] SEL_RF      = 2'b00;
  localparam logic [1:0] SEL_MEMWB   = 2'b01;
  localparam logic [1:0] SEL_EXMEM   = 2'b10;

  // Shadow slots
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_regwrite_q, ex_regwrite_d;
  logic       ex_memread_q, ex_memread_d;
  logic       ex_memwrite_q, ex_memwrite_d;
  logic       mem_valid_q, mem_valid_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic       mem_regwrite_q, mem_regwrite_d;
  logic       mem_memread_q, mem_memread_d;
  logic       mem_memwrite_q, mem_memwrite_d;

  logic [1:0]  fwd_a_q, fwd_a_d;
  logic [1:0]  fwd_b_q, fwd_b_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [0:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;

  logic       mem_access, hold, flush, stall, bubble, load_use;
  logic       ex_prod_rs1, ex_prod_rs2, mem_prod_rs1, mem_prod_rs2;
  logic [1:0] sel_a, sel_b;

  // Hazard detection from the registered shadows and the current ID instruction
  always_comb begin
    ex_prod_rs1  = ex_valid_q & ex_regwrite_q & (ex_rd_q != 5'd0) & (ex_rd_q == id_rs1_i);
    ex_prod_rs2  = ex_valid_q & ex_regwrite_q & (ex_rd_q != 5'd0) & (ex_rd_q == id_rs2_i);
    mem_prod_rs1 = mem_valid_q & mem_regwrite_q & (mem_rd_q != 5'd0) & (mem_rd_q == id_rs1_i);
    mem_prod_rs2 = mem_valid_q & mem_regwrite_q & (mem_rd_q != 5'd0) & (mem_rd_q == id_rs2_i);

    // The MEM slot stays frozen while waiting, so this also covers MEM_WAIT.
    mem_access = mem_valid_q & (mem_memread_q | mem_memwrite_q);
    hold       = mem_access & ~dmem_ready_i;

    load_use = id_valid_i & ex_memread_q &
               ((id_use_rs1_i & ex_prod_rs1) | (id_use_rs2_i & ex_prod_rs2));
    // A taken branch squashes the consumer, so it overrides the stall.
    flush  = ~hold & branch_taken_i;
    stall  = ~hold & ~branch_taken_i & load_use;
    bubble = flush | stall;

    // The newer producer (EX slot) wins over the MEM slot.
    sel_a = SEL_RF;
    if (id_use_rs1_i) begin
      if (ex_prod_rs1)       sel_a = SEL_EXMEM;
      else if (mem_prod_rs1) sel_a = SEL_MEMWB;
    end
    sel_b = SEL_RF;
    if (id_use_rs2_i) begin
      if (ex_prod_rs2)       sel_b = SEL_EXMEM;
      else if (mem_prod_rs2) sel_b = SEL_MEMWB;
    end
  end

  assign hold_o         = hold;
  assign pc_write_o     = ~hold & ~stall;
  assign if_id_write_o  = ~hold & ~stall;
  assign id_ex_bubble_o = bubble;
  assign if_id_flush_o  = flush;
  assign fwd_a_o        = fwd_a_q;
  assign fwd_b_o        = fwd_b_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign err_o          = err_q;

  // Next-state for shadows, forwarding selects, stall counter and wait FSM
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memread_d   = ex_memread_q;
    ex_memwrite_d  = ex_memwrite_q;
    mem_valid_d    = mem_valid_q;
    mem_rd_d       = mem_rd_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_memread_d  = mem_memread_q;
    mem_memwrite_d = mem_memwrite_q;
    fwd_a_d        = fwd_a_q;
    fwd_b_d        = fwd_b_q;
    stall_cnt_d    = stall_cnt_q;

    if (!hold) begin
      mem_valid_d    = ex_valid_q;
      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      mem_memread_d  = ex_memread_q;
      mem_memwrite_d = ex_memwrite_q;
      if (bubble) begin
        ex_valid_d    = 1'b0;
        ex_rd_d       = 5'd0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_memwrite_d = 1'b0;
        fwd_a_d       = SEL_RF;
        fwd_b_d       = SEL_RF;
      end else begin
        ex_valid_d    = id_valid_i;
        ex_rd_d       = id_rd_i;
        ex_regwrite_d = id_regwrite_i;
        ex_memread_d  = id_memread_i;
        ex_memwrite_d = id_memwrite_i;
        fwd_a_d       = id_valid_i ? sel_a : SEL_RF;
        fwd_b_d       = id_valid_i ? sel_b : SEL_RF;
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    state_d    = state_q;
    wait_cnt_d = 8'd0;
    err_d      = err_q;
    case (state_q)
      ST_RUN: begin
        if (hold) state_d = ST_MEM_WAIT;
      end
      default: begin
        if (dmem_ready_i) state_d = ST_RUN;
        wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        // Sticky flag only; the access is still allowed to complete.
        if (wait_cnt_d >= WAIT_LIMIT) err_d = 1'b1;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= 5'd0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      fwd_a_q        <= SEL_RF;
      fwd_b_q        <= SEL_RF;
      stall_cnt_q    <= 16'd0;
      state_q        <= ST_RUN;
      wait_cnt_q     <= 8'd0;
      err_q          <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      ex_memwrite_q  <= ex_memwrite_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memread_q  <= mem_memread_d;
      mem_memwrite_q <= mem_memwrite_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_cnt_q    <= stall_cnt_d;
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      err_q          <= err_d;
    end
  end

endmodule
